// File: rtl/adc_ddr_tx.sv
// adc_ddr_tx: source-synchronous DDR sample transmitter.
// Accepts {or, sample} words into a small FIFO and sends each word as two lane
// phases. The even bits go out with dco_out high, then the odd bits go out with
// dco_out low. Pattern modes (ramp, alternating, constant) replace FIFO data for
// bring-up of the capture path.
module adc_ddr_tx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] IDLE_WORD  = 16'h0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [1:0]                    pattern_mode,
  input  logic [15:0]                   sample_in,
  input  logic                          or_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic [7:0]                    lane_out,
  output logic                          dco_out,
  output logic                          or_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FullLevel = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] LevelOne  = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne  = AW'(1);

  localparam logic [1:0] ModeFifo = 2'b00;
  localparam logic [1:0] ModeRamp = 2'b01;
  localparam logic [1:0] ModeAlt  = 2'b10;
  localparam logic [1:0] ModeIdle = 2'b11;

  // Phase of the word on the wire: even bits first, then odd bits.
  typedef enum logic {StEven, StOdd} ph_e;

  ph_e ph_q, ph_d;

  // FIFO storage and bookkeeping.
  logic [16:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          push, pop;
  logic          fifo_empty;
  logic [16:0]   head;

  // Transmit-side state.
  logic [7:0]  lane_q, lane_d;
  logic        dco_q, dco_d;
  logic        or_q, or_d;
  logic [7:0]  odd_hold_q, odd_hold_d;
  logic [15:0] ramp_q, ramp_d;
  logic        alt_q, alt_d;
  logic        underrun_q, underrun_d;

  // Selected word and its split into lane phases.
  logic [15:0] word;
  logic [7:0]  even_bits, odd_bits;

  assign sample_ready = (level_q != FullLevel);
  assign push         = sample_valid && sample_ready;
  assign fifo_empty   = (level_q == '0);
  assign head         = mem_q[rd_ptr_q];

  assign lane_out   = lane_q;
  assign dco_out    = dco_q;
  assign or_out     = or_q;
  assign fifo_level = level_q;
  assign underrun   = underrun_q;

  // FIFO data array; no reset needed since occupancy is tracked by level_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {or_in, sample_in};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LevelOne;
        2'b01:   level_q <= level_q - LevelOne;
        default: level_q <= level_q;
      endcase
    end
  end

  // Word candidate for the next even phase. Emptiness uses the registered level,
  // so a word pushed on the same edge is not visible until the following word.
  always_comb begin
    word = IDLE_WORD;
    case (pattern_mode)
      ModeFifo: word = fifo_empty ? IDLE_WORD : head[15:0];
      ModeRamp: word = ramp_q;
      ModeAlt:  word = alt_q ? 16'h5555 : 16'hAAAA;
      ModeIdle: word = IDLE_WORD;
      default:  word = IDLE_WORD;
    endcase
  end

  // Split the word: lane i carries bits {2i+1, 2i}.
  always_comb begin
    even_bits = '0;
    odd_bits  = '0;
    for (int i = 0; i < 8; i++) begin
      even_bits[i] = word[2*i];
      odd_bits[i]  = word[2*i+1];
    end
  end

  // Phase state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_q <= StEven;
    end else begin
      ph_q <= ph_d;
    end
  end

  // Phase next-state: a started word always finishes its odd phase.
  always_comb begin
    ph_d = ph_q;
    unique case (ph_q)
      StEven:  ph_d = enable ? StOdd : StEven;
      StOdd:   ph_d = StEven;
      default: ph_d = StEven;
    endcase
  end

  // Output and pattern-generator next values, decided by the current phase.
  always_comb begin
    lane_d     = lane_q;
    dco_d      = dco_q;
    or_d       = or_q;
    odd_hold_d = odd_hold_q;
    ramp_d     = ramp_q;
    alt_d      = alt_q;
    underrun_d = underrun_q;
    pop        = 1'b0;
    unique case (ph_q)
      StEven: begin
        if (enable) begin
          lane_d     = even_bits;
          odd_hold_d = odd_bits;
          dco_d      = 1'b1;
          or_d       = 1'b0;
          case (pattern_mode)
            ModeFifo: begin
              if (fifo_empty) begin
                underrun_d = 1'b1;
              end else begin
                pop  = 1'b1;
                or_d = head[16];
              end
            end
            ModeRamp: ramp_d = ramp_q + 16'd1;
            ModeAlt:  alt_d  = ~alt_q;
            default:  ;
          endcase
        end else begin
          lane_d = '0;
          dco_d  = 1'b0;
          or_d   = 1'b0;
        end
      end
      StOdd: begin
        // or_out stays with the word through its odd phase.
        lane_d = odd_hold_q;
        dco_d  = 1'b0;
      end
      default: ;
    endcase
  end

  // Registered outputs and pattern generators; reset aborts a word in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q     <= '0;
      dco_q      <= 1'b0;
      or_q       <= 1'b0;
      odd_hold_q <= '0;
      ramp_q     <= '0;
      alt_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      lane_q     <= lane_d;
      dco_q      <= dco_d;
      or_q       <= or_d;
      odd_hold_q <= odd_hold_d;
      ramp_q     <= ramp_d;
      alt_q      <= alt_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_adc_ddr_tx.sv
// Self-checking bench for adc_ddr_tx: directed table, corner sequences, and a
// randomized run compared against a queue-based reference model.
module tb_adc_ddr_tx;

  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] IDLE  = 16'h0000;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  pattern_mode;
  logic [15:0] sample_in;
  logic        or_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [7:0]  lane_out;
  logic        dco_out;
  logic        or_out;
  logic [2:0]  fifo_level;
  logic        underrun;

  int n_tests;
  int n_fail;

  adc_ddr_tx #(
    .FIFO_DEPTH (DEPTH),
    .IDLE_WORD  (IDLE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pattern_mode (pattern_mode),
    .sample_in    (sample_in),
    .or_in        (or_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .lane_out     (lane_out),
    .dco_out      (dco_out),
    .or_out       (or_out),
    .fifo_level   (fifo_level),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] evens(input logic [15:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[2*i];
    return r;
  endfunction

  function automatic logic [7:0] odds(input logic [15:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[2*i+1];
    return r;
  endfunction

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic en, input logic [1:0] mode, input logic vld,
                        input logic [15:0] data, input logic orf);
    enable       = en;
    pattern_mode = mode;
    sample_valid = vld;
    sample_in    = data;
    or_in        = orf;
  endtask

  task automatic do_reset();
    set_in(1'b0, 2'b00, 1'b0, 16'h0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [7:0] lane, input logic dco,
                           input logic orx, input logic [2:0] lvl, input logic und);
    check({tag, ".lane"},  lane_out, lane);
    check({tag, ".dco"},   dco_out, dco);
    check({tag, ".or"},    or_out, orx);
    check({tag, ".level"}, fifo_level, lvl);
    check({tag, ".under"}, underrun, und);
    check({tag, ".ready"}, sample_ready, lvl != DEPTH);
  endtask

  // ---------------- reference model ----------------
  logic [16:0] mq[$];
  bit          m_odd_ph;
  logic [7:0]  m_lane, m_hold;
  bit          m_dco, m_or, m_under, m_alt;
  logic [15:0] m_ramp;

  task automatic model_reset();
    mq.delete();
    m_odd_ph = 0; m_lane = '0; m_hold = '0; m_dco = 0; m_or = 0;
    m_under = 0; m_alt = 0; m_ramp = '0;
  endtask

  // One clock edge of behaviour, using the inputs currently applied.
  task automatic model_step();
    bit          can_push;
    logic [15:0] w;
    logic [16:0] e;
    bit          o;
    can_push = sample_valid && (mq.size() < DEPTH);
    if (m_odd_ph) begin
      m_lane   = m_hold;
      m_dco    = 0;
      m_odd_ph = 0;
    end else if (enable) begin
      o = 0;
      w = IDLE;
      case (pattern_mode)
        2'd0: begin
          if (mq.size() == 0) m_under = 1;
          else begin
            e = mq.pop_front();
            w = e[15:0];
            o = e[16];
          end
        end
        2'd1: begin w = m_ramp; m_ramp = m_ramp + 16'd1; end
        2'd2: begin w = m_alt ? 16'h5555 : 16'hAAAA; m_alt = ~m_alt; end
        default: w = IDLE;
      endcase
      m_lane   = evens(w);
      m_hold   = odds(w);
      m_dco    = 1;
      m_or     = o;
      m_odd_ph = 1;
    end else begin
      m_lane = '0; m_dco = 0; m_or = 0;
    end
    if (can_push) mq.push_back({or_in, sample_in});
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        en;
    logic [1:0]  mode;
    logic        vld;
    logic [15:0] data;
    logic        orf;
    logic [7:0]  lane;
    logic        dco;
    logic        or_o;
    logic [2:0]  lvl;
    logic        und;
  } vec_t;

  vec_t tbl[22];

  initial begin
    logic [15:0] words[5];
    reset = 1'b1;
    n_tests = 0;
    n_fail  = 0;
    set_in(1'b0, 2'b00, 1'b0, 16'h0, 1'b0);

    //            en    mode   vld   data      or  | lane   dco   or    lvl   und
    tbl[0]  = '{1'b0, 2'd0, 1'b1, 16'h8001, 1'b1, 8'h00, 1'b0, 1'b0, 3'd1, 1'b0};
    tbl[1]  = '{1'b1, 2'd0, 1'b0, 16'h0000, 1'b0, 8'h01, 1'b1, 1'b1, 3'd0, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 16'h0000, 1'b0, 8'h80, 1'b0, 1'b1, 3'd0, 1'b0};
    tbl[3]  = '{1'b1, 2'd0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 16'h1234, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 1'b1};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 1'b1};
    tbl[6]  = '{1'b1, 2'd2, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1};
    tbl[7]  = '{1'b1, 2'd2, 1'b0, 16'h0000, 1'b0, 8'hFF, 1'b0, 1'b0, 3'd1, 1'b1};
    tbl[8]  = '{1'b1, 2'd2, 1'b0, 16'h0000, 1'b0, 8'hFF, 1'b1, 1'b0, 3'd1, 1'b1};
    tbl[9]  = '{1'b1, 2'd2, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 1'b1};
    tbl[10] = '{1'b1, 2'd0, 1'b0, 16'h0000, 1'b0, 8'h46, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[11] = '{1'b1, 2'd0, 1'b0, 16'h0000, 1'b0, 8'h14, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[12] = '{1'b1, 2'd1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[13] = '{1'b1, 2'd1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[14] = '{1'b1, 2'd1, 1'b0, 16'h0000, 1'b0, 8'h01, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[15] = '{1'b1, 2'd1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[16] = '{1'b1, 2'd1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[17] = '{1'b1, 2'd1, 1'b0, 16'h0000, 1'b0, 8'h01, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[18] = '{1'b1, 2'd3, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[19] = '{1'b1, 2'd3, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1};
    tbl[20] = '{1'b1, 2'd1, 1'b0, 16'h0000, 1'b0, 8'h01, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[21] = '{1'b1, 2'd1, 1'b0, 16'h0000, 1'b0, 8'h01, 1'b0, 1'b0, 3'd0, 1'b1};

    // Reset values.
    do_reset();
    check_all("reset", 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);

    for (int r = 0; r < 22; r++) begin
      set_in(tbl[r].en, tbl[r].mode, tbl[r].vld, tbl[r].data, tbl[r].orf);
      tick();
      check_all($sformatf("tbl%0d", r), tbl[r].lane, tbl[r].dco, tbl[r].or_o, tbl[r].lvl,
                tbl[r].und);
    end

    // Fill with enable low: fifth word refused, then four words in order.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      words[k] = 16'($urandom);
      set_in(1'b0, 2'd0, 1'b1, words[k], k[0]);
      tick();
      check($sformatf("fill%0d.level", k), fifo_level, (k < 4) ? k + 1 : 4);
      check($sformatf("fill%0d.ready", k), sample_ready, k < 3);
    end
    set_in(1'b1, 2'd0, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("drain%0d.even", k), lane_out, evens(words[k]));
      check($sformatf("drain%0d.dco1", k), dco_out, 1'b1);
      check($sformatf("drain%0d.or", k), or_out, k[0]);
      tick();
      check($sformatf("drain%0d.odd", k), lane_out, odds(words[k]));
      check($sformatf("drain%0d.dco0", k), dco_out, 1'b0);
    end
    check("drain.under0", underrun, 1'b0);
    check("drain.level0", fifo_level, 0);
    tick();
    check("drain.idle", lane_out, evens(IDLE));
    check("drain.under1", underrun, 1'b1);

    // Enable dropped after the even phase: odd phase still completes.
    do_reset();
    set_in(1'b1, 2'd2, 1'b0, 16'h0, 1'b0);
    tick();
    check("endrop.even", lane_out, 8'h00);
    check("endrop.dco1", dco_out, 1'b1);
    enable = 1'b0;
    tick();
    check("endrop.odd", lane_out, 8'hFF);
    check("endrop.dco0", dco_out, 1'b0);
    tick();
    check("endrop.idle_lane", lane_out, 8'h00);
    check("endrop.idle_dco", dco_out, 1'b0);

    // Reset asserted during an even phase with data in the FIFO.
    do_reset();
    set_in(1'b0, 2'd0, 1'b1, 16'hBEEF, 1'b1);
    tick();
    tick();
    set_in(1'b1, 2'd1, 1'b0, 16'h0, 1'b0);
    tick();
    tick();
    tick();
    check("rstmid.lane", lane_out, 8'h01);
    check("rstmid.dco", dco_out, 1'b1);
    check("rstmid.level", fifo_level, 2);
    #2 reset = 1'b1;
    #1;
    check_all("rstmid.async", 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    #1 reset = 1'b0;
    set_in(1'b1, 2'd0, 1'b0, 16'h0, 1'b0);
    tick();
    check("rstmid.empty_under", underrun, 1'b1);
    check("rstmid.empty_lane", lane_out, evens(IDLE));

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      int unsigned r;
      r = $urandom_range(0, 7);
      set_in($urandom_range(0, 9) < 8, (r < 4) ? 2'd0 : 2'(r - 4), 1'($urandom),
             16'($urandom), 1'($urandom));
      model_step();
      tick();
      check_all($sformatf("rnd%0d", n), m_lane, m_dco, m_or, 3'(mq.size()), m_under);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_ddr_tx.md
# adc_ddr_tx

Source-synchronous transmitter for the ADC-style 8-lane DDR sample bus: accepts 16-bit samples (plus over-range flag) on a valid/ready interface, buffers them in a small FIFO, and emits each sample as two lane phases (even bits, then odd bits) with a forwarded DCO strobe. It is the transmit-side counterpart of the ADC DDR capture path. It serves as a loopback/ADC emulator for bring-up of the capture chain, and as a driver for DAC-style DDR links.

## Interface
- FIFO_DEPTH, 4, sample FIFO depth in words; power of 2, ≥2
- IDLE_WORD, 16'h0000, word transmitted on underrun

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- enable  in  1  transmit enable, sampled only at word boundaries
- pattern_mode  in  2  00 FIFO data, 01 ramp, 10 alternating 16'hAAAA/16'h5555, 11 constant IDLE_WORD
- sample_in  in  16  sample word
- or_in  in  1  over-range flag, travels with sample_in
- sample_valid  in  1  sample_in/or_in valid
- sample_ready  out  1  FIFO not full; transfer on valid&&ready
- lane_out  out  8  DDR lanes; lane i carries bits {2i+1, 2i}
- dco_out  out  1  forwarded strobe, 1 during even phase, 0 during odd phase
- or_out  out  1  over-range of word in flight
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy
- underrun  out  1  sticky; set when mode 00 needs a word and FIFO is empty

## Operation
- FIFO stores 17 bits ({or, sample}). Push on posedge with sample_valid&&sample_ready. sample_ready = (fifo_level != FIFO_DEPTH), combinational from registered level.
- Phase register ph (0 = even, 1 = odd) controls the transmit side:
  - ph==0 and enable=1 at posedge: select word W.
    - Mode 00: W = FIFO head, pop. If FIFO empty: W = IDLE_WORD, no pop, underrun<=1.
    - Modes 01/10/11: W = pattern; FIFO not popped and keeps accepting until full.
    - Register outputs: lane_out[i]<=W[2i], dco_out<=1, or_out<=(mode 00 && popped) ? stored or : 0.
    - Latch odd_hold[i]<=W[2i+1]; ph<=1.
  - ph==1 at posedge, regardless of enable: lane_out<=odd_hold, dco_out<=0, or_out unchanged, ph<=0. A started word always completes.
  - ph==0 and enable=0: lane_out<=0, dco_out<=0, or_out<=0, ph stays 0.
- Ramp: 16-bit counter, reset 0. Value used as W, then incremented, once per word emitted in mode 01. Wraps 16'hFFFF→16'h0000. Holds while in other modes.
- Alternating: toggle flop, reset 0. Emits 16'hAAAA when 0, 16'h5555 when 1. Toggles per word emitted in mode 10.
- pattern_mode is sampled at ph==0 edges only. Mid-word changes take effect at the next word.
- Simultaneous push and pop (non-full, non-empty): fifo_level unchanged, order preserved.
- Push into empty FIFO on the same edge as a mode-00 pop: the pushed word is not visible. IDLE_WORD is sent, underrun is set, and the pushed word goes out next word.
- underrun clears only on reset.

## Timing
- Reset values: lane_out 0, dco_out 0, or_out 0, underrun 0, fifo_level 0, sample_ready 1, ph 0, ramp 0, alternate toggle 0; FIFO empty.
- Throughput: one word per 2 clk while enable=1; dco_out frequency is clk/2.
- Latency: sample pushed at edge t, with FIFO otherwise empty and ph==0 at edge t+1, gives even bits on lane_out after edge t+1 and odd bits after edge t+2.
- lane_out, dco_out and or_out change only on clk rising edges (edge-aligned with dco_out). The receiver applies its own delay.
- Asserting reset mid-word aborts it immediately; all outputs return to reset values asynchronously.

## Test plan
- Reset, enable=1, mode 00, push 16'h8001 (or_in=1): lane_out=8'h01 with dco_out=1, then 8'h80 with dco_out=0; or_out=1 both phases; underrun stays 0 if the push preceded the first ph==0 edge.
- Mode 00, FIFO empty, enable=1: lane_out=IDLE_WORD halves, underrun=1 and stays 1 after later pushes, until reset.
- enable=0, push FIFO_DEPTH+1 words with valid held: sample_ready falls after the 4th, fifo_level=4, 5th not accepted. enable=1 then emits the four words in order at one word per 2 clk.
- Mode 01 from reset: words 0,1,2,… Preload ramp to 16'hFFFE (by letting it run): 16'hFFFE, 16'hFFFF, 16'h0000. Mode 10: lanes 8'h00/8'hFF, then 8'hFF/8'h00, alternating.
- Deassert enable during the odd phase: odd phase still completes, then lane_out=0, dco_out=0. Assert reset during an even phase: outputs go to 0 immediately, FIFO empty, fifo_level=0.
